// File: rtl/alu_seq_pkg.sv
// Shared constants, op codes and FSM state type for alu_seq.
// ALU_SEQ_DIV_EN adds the DIV state used by the iterative divider.
package alu_seq_pkg;

   localparam int DEFAULT_WIDTH = 32;

   localparam int OP_AND  = 0;
   localparam int OP_OR   = 1;
   localparam int OP_ADD  = 2;
   localparam int OP_XOR  = 3;
   localparam int OP_SLL  = 4;
   localparam int OP_SRL  = 5;
   localparam int OP_SUB  = 6;
   localparam int OP_SLT  = 7;
   localparam int OP_ROTL = 8;
   localparam int OP_ROTR = 9;
   localparam int OP_NOR  = 12;
   localparam int OP_DIV  = 13;
   localparam int OP_ONES = 14;
   localparam int OP_MUL  = 15;

`ifdef ALU_SEQ_DIV_EN
   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd3} state_t;
`endif

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier and (with ALU_SEQ_DIV_EN) restoring divider.
// hi/lo show the result of the step taking effect at the next edge; they are final while done is high.
module alu_iter_muldiv
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH);

   logic [WIDTH-1:0] hi_q, lo_q, opd_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] mul_hi, mul_lo;

   // Multiply: hi_q accumulates, lo_q holds the multiplier shifting out LSB first.
   assign sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
   assign mul_hi = sum[WIDTH:1];
   assign mul_lo = {sum[0], lo_q[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
   logic             mode_q;
   logic [WIDTH:0]   rs, diff;
   logic             ge;

   // Divide: hi_q is the partial remainder, lo_q shifts dividend out and quotient in.
   assign rs   = {hi_q, lo_q[WIDTH-1]};
   assign ge   = (rs >= {1'b0, opd_q});
   assign diff = rs - {1'b0, opd_q};
   assign hi   = mode_q ? (ge ? diff[WIDTH-1:0] : rs[WIDTH-1:0]) : mul_hi;
   assign lo   = mode_q ? {lo_q[WIDTH-2:0], ge} : mul_lo;
`else
   logic unused_mode;
   assign unused_mode = mode;
   assign hi = mul_hi;
   assign lo = mul_lo;
`endif

   assign busy = busy_q;
   assign done = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q   <= '0;
         lo_q   <= '0;
         opd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
         mode_q <= 1'b0;
`endif
      end else if (start) begin
         hi_q   <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
         mode_q <= mode;
         lo_q   <= mode ? a : b;
         opd_q  <= mode ? b : a;
`else
         lo_q   <= b;
         opd_q  <= a;
`endif
      end else if (busy_q) begin
         hi_q  <= hi;
         lo_q  <= lo;
         cnt_q <= cnt_q + 1'b1;
         if (done) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready request and result handshakes and an iterative mul/div.
// ALU_SEQ_DIV_EN enables the divider (op 13); otherwise op 13 yields 0 like any unsupported code.
// Handshake: a request transfers on a cycle with InValid && InReady; a result transfers on
// OutValid && OutReady. InReady is high only in IDLE outside Reset; results hold while OutValid.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int CTRL_W = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              InValid,
   output logic              InReady,
   input  logic [CTRL_W-1:0] ALUControl,
   input  logic [WIDTH-1:0]  A,
   input  logic [WIDTH-1:0]  B,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [WIDTH-1:0]  ALUResult,
   output logic [WIDTH-1:0]  ALUResultHi,
   output logic              Zero,
   output logic [1:0]        State
);

   localparam int SH_W = $clog2(WIDTH);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   single_res;
   logic [SH_W-1:0]    sh;
   logic [2*WIDTH-1:0] rotl_w, rotr_w;
   logic               accept, is_mul, load_single;
   logic               md_start, md_mode, md_busy, md_done;
   logic [WIDTH-1:0]   md_hi, md_lo;
   logic               unused_sink;

   assign sh     = B[SH_W-1:0];
   assign rotl_w = {A, A} << sh;
   assign rotr_w = {A, A} >> sh;
   assign is_mul = (int'(ALUControl) == OP_MUL);
   assign unused_sink = ^{rotl_w[WIDTH-1:0], rotr_w[2*WIDTH-1:WIDTH], md_busy};

`ifdef ALU_SEQ_DIV_EN
   logic is_div;
   assign is_div = (int'(ALUControl) == OP_DIV);
`endif

   always_comb begin
      single_res = '0;
      case (int'(ALUControl))
         OP_AND:  single_res = A & B;
         OP_OR:   single_res = A | B;
         OP_ADD:  single_res = A + B;
         OP_XOR:  single_res = A ^ B;
         OP_SLL:  single_res = A << sh;
         OP_SRL:  single_res = A >> sh;
         OP_SUB:  single_res = A - B;
         OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         OP_ROTL: single_res = rotl_w[2*WIDTH-1:WIDTH];
         OP_ROTR: single_res = rotr_w[WIDTH-1:0];
         OP_NOR:  single_res = ~(A | B);
         OP_ONES: single_res = '1;
         default: single_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      md_start = 1'b0;
      md_mode  = 1'b0;
      InReady  = (state_q == IDLE) && !Reset;
      accept   = InValid && InReady;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_mul) begin
                  state_d  = MUL;
                  md_start = 1'b1;
`ifdef ALU_SEQ_DIV_EN
               end else if (is_div) begin
                  state_d  = DIV;
                  md_start = 1'b1;
                  md_mode  = 1'b1;
`endif
               end else begin
                  state_d = DONE;
               end
            end
         end
         MUL:     if (md_done) state_d = DONE;
`ifdef ALU_SEQ_DIV_EN
         DIV:     if (md_done) state_d = DONE;
`endif
         DONE:    if (OutReady) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Single-cycle ops only ever go IDLE -> DONE, so that transition marks their load.
   assign load_single = accept && (state_d == DONE);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         ALUResult   <= '0;
         ALUResultHi <= '0;
         Zero        <= 1'b1;
      end else begin
         state_q <= state_d;
         if (load_single) begin
            ALUResult   <= single_res;
            ALUResultHi <= '0;
            Zero        <= (single_res == '0);
         end else if (md_done) begin
            ALUResult   <= md_lo;
            ALUResultHi <= md_hi;
            Zero        <= (md_lo == '0);
         end
      end
   end

   assign OutValid = (state_q == DONE);
   assign State    = state_q;

   alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk   (Clk),
      .rst   (Reset),
      .start (md_start),
      .mode  (md_mode),
      .a     (A),
      .b     (B),
      .busy  (md_busy),
      .done  (md_done),
      .hi    (md_hi),
      .lo    (md_lo)
   );

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=32; follows ALU_SEQ_DIV_EN for op 13 expectations.
module tb_alu_seq;

   localparam int W = 32;

   logic          Clk = 1'b0;
   logic          Reset = 1'b1;
   logic          InValid = 1'b0;
   logic          InReady;
   logic [3:0]    ALUControl = '0;
   logic [W-1:0]  A = '0;
   logic [W-1:0]  B = '0;
   logic          OutValid;
   logic          OutReady = 1'b0;
   logic [W-1:0]  ALUResult;
   logic [W-1:0]  ALUResultHi;
   logic          Zero;
   logic [1:0]    state_dbg;

   logic [2*W-1:0] exp_q[$];
   int             exp_lat;
   int             n_tests = 0;
   int             n_fail = 0;

   alu_seq #(.WIDTH(W), .CTRL_W(4)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .InValid     (InValid),
      .InReady     (InReady),
      .ALUControl  (ALUControl),
      .A           (A),
      .B           (B),
      .OutValid    (OutValid),
      .OutReady    (OutReady),
      .ALUResult   (ALUResult),
      .ALUResultHi (ALUResultHi),
      .Zero        (Zero),
      .State       (state_dbg)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: {hi, lo}
   function automatic logic [2*W-1:0] model(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0]   r;
      logic [2*W-1:0] p;
      int             s;
      s = int'(b[4:0]);
      r = '0;
      case (op)
         0:  r = a & b;
         1:  r = a | b;
         2:  r = a + b;
         3:  r = a ^ b;
         4:  r = a << s;
         5:  r = a >> s;
         6:  r = a - b;
         7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         8:  r = (a << s) | (a >> (32 - s));
         9:  r = (a >> s) | (a << (32 - s));
         12: r = ~(a | b);
         14: r = 32'hFFFF_FFFF;
         15: begin
            p = {32'd0, a} * {32'd0, b};
            return p;
         end
`ifdef ALU_SEQ_DIV_EN
         13: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
`endif
         default: r = '0;
      endcase
      return {32'd0, r};
   endfunction

   function automatic int latency(input int op);
      if (op == 15) return W + 1;
`ifdef ALU_SEQ_DIV_EN
      if (op == 13) return W + 1;
`endif
      return 1;
   endfunction

   // Called near a negedge; request is accepted at the following posedge.
   task automatic start_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      n = 0;
      while (!InReady && n < 100) begin
         @(negedge Clk);
         n++;
      end
      if (!InReady) check("ready_timeout", 64'(InReady), 64'd1);
      ALUControl = 4'(op);
      A = a;
      B = b;
      InValid = 1'b1;
      exp_q.push_back(model(op, a, b));
      exp_lat = latency(op);
      @(posedge Clk);
      #1;
      InValid = 1'b0;
      A = $urandom;
      B = $urandom;
      ALUControl = 4'($urandom_range(0, 15));
   endtask

   task automatic finish_op(input string tag, input int hold, input bit pulse);
      int             cyc;
      logic [2*W-1:0] e;
      cyc = 0;
      while (cyc < 100) begin
         @(negedge Clk);
         cyc++;
         if (OutValid) break;
         if (pulse) begin
            check({tag, "_busy_ready"}, 64'(InReady), 64'd0);
            InValid = 1'($urandom_range(0, 1));
            ALUControl = 4'($urandom_range(0, 15));
            A = $urandom;
            B = $urandom;
         end
      end
      InValid = 1'b0;
      check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 64'd0, 64'd1);
         e = '0;
      end else begin
         e = exp_q.pop_front();
      end
      check({tag, "_lo"}, 64'(ALUResult), 64'(e[W-1:0]));
      check({tag, "_hi"}, 64'(ALUResultHi), 64'(e[2*W-1:W]));
      check({tag, "_zero"}, 64'(Zero), 64'(e[W-1:0] == 0));
      for (int i = 0; i < hold; i++) begin
         A = $urandom;
         B = $urandom;
         @(negedge Clk);
         check({tag, "_hold_valid"}, 64'(OutValid), 64'd1);
         check({tag, "_hold_lo"}, 64'(ALUResult), 64'(e[W-1:0]));
         check({tag, "_hold_hi"}, 64'(ALUResultHi), 64'(e[2*W-1:W]));
      end
      OutReady = 1'b1;
      @(negedge Clk);
      OutReady = 1'b0;
      check({tag, "_idle_valid"}, 64'(OutValid), 64'd0);
      check({tag, "_idle_ready"}, 64'(InReady), 64'd1);
   endtask

   task automatic do_op(input string tag, input int op, input logic [W-1:0] a, input logic [W-1:0] b);
      start_op(op, a, b);
      finish_op(tag, 0, 1'b0);
   endtask

   initial begin
      int op;
      repeat (3) @(negedge Clk);
      check("rst_valid", 64'(OutValid), 64'd0);
      check("rst_ready", 64'(InReady), 64'd0);
      check("rst_lo", 64'(ALUResult), 64'd0);
      check("rst_hi", 64'(ALUResultHi), 64'd0);
      check("rst_zero", 64'(Zero), 64'd1);
      Reset = 1'b0;
      #1;
      check("rst_release_ready", 64'(InReady), 64'd1);

      do_op("add_wrap", 2, 32'hFFFF_FFFF, 32'd1);
      do_op("slt_neg", 7, 32'hFFFF_FFFE, 32'd1);
      do_op("rotr_1", 9, 32'h8000_0001, 32'd1);
      do_op("rotl_32", 8, 32'h1234_5678, 32'd32);
      do_op("rotr_0", 9, 32'hDEAD_BEEF, 32'd0);
      do_op("rotl_4", 8, 32'h1234_5678, 32'd4);
      do_op("sll_31", 4, 32'h0000_0003, 32'd31);
      do_op("sub_wrap", 6, 32'd0, 32'd1);
      do_op("code10", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      start_op(15, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      finish_op("mul_max", 0, 1'b1);
      do_op("mul_rand", 15, $urandom, $urandom);

      do_op("div_100_7", 13, 32'd100, 32'd7);
      do_op("div_by_0", 13, 32'd100, 32'd0);
      do_op("div_rand", 13, $urandom, $urandom_range(1, 1000));

      start_op(3, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
      finish_op("hold5", 5, 1'b0);

      // Abandon a multiply partway through
      start_op(15, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (10) @(negedge Clk);
      Reset = 1'b1;
      void'(exp_q.pop_back());
      @(negedge Clk);
      check("midrst_valid", 64'(OutValid), 64'd0);
      check("midrst_zero", 64'(Zero), 64'd1);
      check("midrst_lo", 64'(ALUResult), 64'd0);
      check("midrst_ready", 64'(InReady), 64'd0);
      Reset = 1'b0;
      #1;
      check("midrst_ready_after", 64'(InReady), 64'd1);
      for (int i = 0; i < W + 3; i++) begin
         @(negedge Clk);
         if (OutValid) check("midrst_stale_result", 64'(OutValid), 64'd0);
      end
      check("midrst_no_result", 64'(OutValid), 64'd0);
      do_op("after_rst_add", 2, 32'd40, 32'd2);
      do_op("after_rst_mul", 15, 32'd1000, 32'd1000);

      for (int i = 0; i < 24; i++) begin
         op = $urandom_range(0, 14);
         do_op("rand_op", op, $urandom, $urandom);
      end

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
